data_request_unit: RTL and testbench

DATA_REQUEST_UNIT -- requirements
Module: data_request_unit

---
 rtl/data_request_unit.sv | 121 ++++++++++++
 tb/tb_data_request_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_request_unit.sv
// data_request_unit: single-outstanding load/store bus requester with 255-cycle timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module data_request_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_adr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        done,
    output logic        bus_error,
    output logic        misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        st_q, st_d, err_q, err_d, mis_q, mis_d;
    logic [1:0]  lo;
    logic        mis_in;
    logic [31:0] sh, ld_ext;
    logic [3:0]  sel;

    always_comb begin
        lo = funct3[1:0] == 2'b00 ? addr[1:0] : funct3[1:0] == 2'b01 ? {addr[1], 1'b0} : 2'b00;
`ifdef MISALIGN_TRAP_EN
        mis_in = funct3[1:0] == 2'b01 ? addr[0] : funct3[1] && addr[1:0] != 2'b00;
`else
        mis_in = 1'b0;
`endif
        sh = bus_rdata >> {addr_q[1:0], 3'b000};
        ld_ext = funct3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]}
               : funct3_q == 3'b100 ? {24'b0, sh[7:0]}
               : funct3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]}
               : funct3_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        st_d        = st_q;
        err_d       = err_q;
        mis_d       = mis_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: if (load || store) begin
                addr_d   = {addr[31:2], lo};
                wdata_d  = store_data;
                funct3_d = funct3;
                st_d     = store;
                err_d    = 1'b0;
                mis_d    = mis_in;
                cnt_d    = 8'd0;
                state_d  = mis_in ? DONE : REQ;
            end
            REQ: begin
                cnt_d = bus_ack ? cnt_q : cnt_q + 8'd1;
                if (bus_ack) begin
                    state_d     = DONE;
                    load_data_d = st_q ? load_data_q : ld_ext;
                end else if (cnt_q == 8'd254) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            st_q        <= 1'b0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            cnt_q       <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            st_q        <= st_d;
            err_q       <= err_d;
            mis_q       <= mis_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
        end
    end

    assign sel = funct3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
               : funct3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign bus_read   = state_q == REQ && !st_q;
    assign bus_write  = state_q == REQ && st_q;
    assign bus_sel    = state_q == REQ ? sel : 4'b0000;
    assign bus_adr    = {addr_q[31:2], 2'b00};
    assign bus_wdata  = funct3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                      : funct3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign stall      = state_q == REQ || (state_q == IDLE && (load || store));
    assign load_data  = load_data_q;
    assign done       = state_q == DONE;
    assign load_valid = state_q == DONE && !st_q && !err_q && !mis_q;
    assign bus_error  = state_q == DONE && err_q;
    assign misaligned = state_q == DONE && mis_q;
endmodule

// File: tb/tb_data_request_unit.sv
// tb_data_request_unit: directed and randomized accesses checked against a transaction-level model.
module tb_data_request_unit;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, store = 1'b0, bus_ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0, bus_rdata = '0;
    logic        bus_read, bus_write, stall, load_valid, done, bus_error, misaligned;
    logic [31:0] bus_adr, bus_wdata, load_data;
    logic [3:0]  bus_sel;
    int          checks = 0, failures = 0;
    logic [31:0] last_ld = '0;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    data_request_unit dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_adr(bus_adr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .done(done), .bus_error(bus_error), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Byte offset actually used once half/word low bits are forced aligned
    function automatic int eff_lo(input logic [2:0] f3, input logic [31:0] a);
        int sz, b;
        sz = int'(f3[1:0]);
        b  = int'(a[1:0]);
        if (sz == 0) return b;
        if (sz == 1) return (b / 2) * 2;
        return 0;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        int sz, b;
        sz = int'(f3[1:0]);
        b  = int'(a[1:0]);
        if (sz == 1) return b % 2 == 1;
        if (sz >= 2) return b != 0;
        return 0;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] one, two;
        one = 4'b0001;
        two = 4'b0011;
        if (f3[1:0] == 2'b00) return one << eff_lo(f3, a);
        if (f3[1:0] == 2'b01) return two << eff_lo(f3, a);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3[1:0] == 2'b00) return (sd & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * eff_lo(f3, a));
        case (f3)
            3'd0: begin v = v & 32'hFF; if (v >= 32'h80) v = v | 32'hFFFFFF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int ack_at, input logic [31:0] rd, input bit hold);
        logic [70:0] rg, re;
        logic [10:0] dg, de;
        bit mis, lv, er;
        int exp_n;
        @(negedge clk);
        load = !st || (st && $urandom_range(1) == 1);
        store = st;
        funct3 = f3;
        addr = a;
        store_data = sd;
        bus_ack = 1'($urandom_range(1));
        bus_rdata = $urandom;
        #1;
        dg = {stall, done, load_valid, bus_error, misaligned, bus_read, bus_write, bus_sel};
        checks++;
        if (dg !== {1'b1, 10'b0}) begin
            failures++;
            $display("FAIL idle_request got=%b exp=%b", dg, {1'b1, 10'b0});
        end
        mis = TRAP && is_mis(f3, a);
        exp_n = mis ? 0 : (ack_at <= 255 ? ack_at : 255);
        @(negedge clk);
        if (!hold) begin load = 1'b0; store = 1'b0; end
        addr = $urandom;
        store_data = $urandom;
        funct3 = 3'($urandom);
        for (int n = 1; n <= exp_n + 1; n++) begin
            if (n <= exp_n) begin
                rg = {bus_read, bus_write, bus_sel, bus_adr, bus_wdata, stall};
                re = {!st, st, exp_sel(f3, a), a & 32'hFFFFFFFC, exp_wdata(f3, sd), 1'b1};
                checks++;
                if (rg !== re) begin
                    failures++;
                    $display("FAIL req_cycle%0d got=%h exp=%h", n, rg, re);
                end
                bus_ack = n == ack_at;
                bus_rdata = n == ack_at ? rd : $urandom;
                @(negedge clk);
            end else begin
                lv = !st && !mis && ack_at <= 255;
                er = !mis && ack_at > 255;
                if (lv) last_ld = exp_load(f3, a, rd);
                dg = {done, load_valid, bus_error, misaligned, stall, bus_read, bus_write, bus_sel};
                de = {1'b1, lv, er, mis, 7'b0};
                checks++;
                if (dg !== de) begin
                    failures++;
                    $display("FAIL done_cycle got=%b exp=%b", dg, de);
                end
                checks++;
                if (load_data !== last_ld) begin
                    failures++;
                    $display("FAIL done_load_data got=%h exp=%h", load_data, last_ld);
                end
                bus_ack = 1'($urandom_range(1));
                load = hold;
                store = hold && $urandom_range(1) == 1;
            end
        end
    endtask

    task automatic idle_cycles(input int k);
        logic [10:0] g;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            load = 1'b0;
            store = 1'b0;
            bus_ack = 1'($urandom_range(1));
            bus_rdata = $urandom;
            #1;
            g = {stall, done, load_valid, bus_error, misaligned, bus_read, bus_write, bus_sel};
            checks++;
            if (g !== 11'b0 || load_data !== last_ld) begin
                failures++;
                $display("FAIL idle got=%b/%h exp=%b/%h", g, load_data, 11'b0, last_ld);
            end
        end
    endtask

    task automatic test_reset;
        logic [108:0] g;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        g = {bus_read, bus_write, bus_sel, bus_adr, bus_wdata, stall, load_data, load_valid, done, bus_error, misaligned};
        checks++;
        if (g !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", g);
        end
        last_ld = '0;
    endtask

    task automatic test_load_word;
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        idle_cycles(1);
        checks++;
        if (load_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_literal got=%h exp=%h", load_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_lb_lbu;
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80000000, 1'b0);
        idle_cycles(1);
        checks++;
        if (load_data !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_literal got=%h exp=%h", load_data, 32'hFFFFFF80);
        end
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h80000000, 1'b0);
        idle_cycles(1);
        checks++;
        if (load_data !== 32'h00000080) begin
            failures++;
            $display("FAIL lbu_literal got=%h exp=%h", load_data, 32'h00000080);
        end
    endtask

    task automatic test_store_half;
        run_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 2, 32'h12345678, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_timeout;
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 1000, 32'h0, 1'b0);
        idle_cycles(1);
        run_access(1'b0, 3'b101, 32'h302, 32'h0, 255, 32'hCAFE1234, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_misaligned;
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h89ABCDEF, 1'b0);
        idle_cycles(1);
        run_access(1'b1, 3'b001, 32'h407, 32'h00005A5A, 2, 32'h0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_req;
        logic [108:0] g;
        run_access(1'b0, 3'b010, 32'h500, 32'h0, 1, 32'h13572468, 1'b0);
        @(negedge clk);
        load = 1'b1; funct3 = 3'b010; addr = 32'h600; bus_ack = 1'b0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_req_strobe got=%b exp=1", bus_read);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            g = {bus_read, bus_write, bus_sel, bus_adr, bus_wdata, stall, load_data, load_valid, done, bus_error, misaligned};
            checks++;
            if (g !== '0) begin
                failures++;
                $display("FAIL reset_mid_req%0d got=%h exp=0", i, g);
            end
            @(negedge clk);
            bus_ack = 1'b0;
        end
        last_ld = '0;
    endtask

    task automatic test_back_to_back;
        run_access(1'b0, 3'b001, 32'h702, 32'h0, 1, 32'hBEEF8001, 1'b1);
        run_access(1'b1, 3'b000, 32'h701, 32'h000000C3, 2, 32'h0, 1'b1);
        run_access(1'b0, 3'b110, 32'h704, 32'h0, 1, 32'h0F0F0F0F, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            run_access(1'($urandom_range(1)), 3'($urandom), $urandom, $urandom,
                       int'($urandom_range(1, 5)), $urandom, 1'($urandom_range(1)));
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(1);
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_lb_lbu;
        test_store_half;
        idle_cycles(3);
        test_timeout;
        test_misaligned;
        test_reset_mid_req;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
